// File: rtl/mfp_adc_max10_scan_sequencer_pkg.sv
// Shared definitions for the MAX10 ADC scan sequencer: FSM states and the
// channel/data widths of the Altera ADC Avalon-ST command/response ports.
package mfp_adc_max10_scan_sequencer_pkg;

  localparam int ADC_CH_W   = 5;
  localparam int ADC_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mfp_adc_max10_next_channel.sv
// Masked priority encoder: returns the lowest set mask bit above cur_ch,
// or the lowest set bit overall when first is high.
module mfp_adc_max10_next_channel
  import mfp_adc_max10_scan_sequencer_pkg::*;
#(
  parameter int CH_COUNT = 17
) (
  input  logic [CH_COUNT-1:0] mask,
  input  logic [ADC_CH_W-1:0] cur_ch,
  input  logic                first,
  output logic [ADC_CH_W-1:0] next_ch,
  output logic                found
);

  logic [CH_COUNT-1:0] elig;

  generate
    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_elig
      assign elig[gi] = mask[gi] & (first | (ADC_CH_W'(gi) > cur_ch));
    end
  endgenerate

  // Scan downwards so the lowest eligible index is the one left standing.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = CH_COUNT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        next_ch = ADC_CH_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfp_adc_max10_scan_sequencer.sv
// Walks the enabled channel list, issuing one Avalon-ST command per channel to
// the MAX10 ADC IP and storing each matching response in the result store.
module mfp_adc_max10_scan_sequencer
  import mfp_adc_max10_scan_sequencer_pkg::*;
#(
  parameter int CH_COUNT = 17,
  parameter int TIMEOUT  = 1023
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [CH_COUNT-1:0]   cfg_mask,
  input  logic                  cfg_continuous,
  input  logic                  cfg_trig_en,
  input  logic                  cfg_irq_en,
  input  logic                  sw_start,
  input  logic                  sw_stop,
  input  logic                  irq_clr,
  input  logic                  err_clr,
  input  logic                  ADC_Trigger,
  output logic                  ADC_C_Valid,
  output logic [ADC_CH_W-1:0]   ADC_C_Channel,
  output logic                  ADC_C_SOP,
  output logic                  ADC_C_EOP,
  input  logic                  ADC_C_Ready,
  input  logic                  ADC_R_Valid,
  input  logic [ADC_CH_W-1:0]   ADC_R_Channel,
  input  logic [ADC_DATA_W-1:0] ADC_R_Data,
  output logic                  res_we,
  output logic [ADC_CH_W-1:0]   res_addr,
  output logic [ADC_DATA_W-1:0] res_data,
  output logic                  busy,
  output logic                  done_flag,
  output logic                  err_timeout,
  output logic                  err_channel,
  output logic                  ADC_Interrupt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  seq_state_t            state_reg, state_next;
  logic [CH_COUNT-1:0]   scan_mask_reg, scan_mask_next;
  logic [ADC_CH_W-1:0]   cur_ch_reg, cur_ch_next;
  logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
  logic                  trig_q_reg;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  done_flag_reg, done_flag_next;
  logic                  err_timeout_reg, err_timeout_next;
  logic                  err_channel_reg, err_channel_next;
  logic                  res_we_reg, res_we_next;
  logic [ADC_CH_W-1:0]   res_addr_reg, res_addr_next;
  logic [ADC_DATA_W-1:0] res_data_reg, res_data_next;

  logic                  start_evt;
  logic                  stop_req;
  logic                  done_set, tmo_set, chan_set;
  logic                  enc_use_cfg;
  logic [CH_COUNT-1:0]   enc_mask;
  logic [ADC_CH_W-1:0]   enc_ch;
  logic                  enc_found;

  assign start_evt = sw_start | (cfg_trig_en & ADC_Trigger & ~trig_q_reg);
  assign stop_req  = stop_pend_reg | sw_stop;

  // IDLE and DONE pick the first channel of a fresh snapshot; WAIT_RSP advances
  // through the snapshot taken at scan start.
  assign enc_use_cfg = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign enc_mask    = enc_use_cfg ? cfg_mask : scan_mask_reg;

  mfp_adc_max10_next_channel #(
    .CH_COUNT (CH_COUNT)
  ) u_next_channel (
    .mask    (enc_mask),
    .cur_ch  (cur_ch_reg),
    .first   (enc_use_cfg),
    .next_ch (enc_ch),
    .found   (enc_found)
  );

  always_comb begin
    state_next     = state_reg;
    scan_mask_next = scan_mask_reg;
    cur_ch_next    = cur_ch_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    stop_pend_next = stop_req;
    res_we_next    = 1'b0;
    res_addr_next  = res_addr_reg;
    res_data_next  = res_data_reg;
    done_set       = 1'b0;
    tmo_set        = 1'b0;
    chan_set       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        stop_pend_next = 1'b0;
        if (start_evt && enc_found) begin
          scan_mask_next = cfg_mask;
          cur_ch_next    = enc_ch;
          state_next     = ST_CMD;
        end
      end

      ST_CMD: begin
        if (ADC_C_Ready) begin
          tmo_cnt_next = '0;
          state_next   = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (ADC_R_Valid) begin
          if (ADC_R_Channel == cur_ch_reg) begin
            res_we_next   = 1'b1;
            res_addr_next = cur_ch_reg;
            res_data_next = ADC_R_Data;
          end else begin
            chan_set = 1'b1;
          end
          if (enc_found) begin
            cur_ch_next = enc_ch;
            state_next  = ST_CMD;
          end else begin
            state_next = ST_DONE;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          tmo_set    = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_cnt_reg != TMO_MAX) begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end

      ST_DONE: begin
        done_set   = 1'b1;
        state_next = ST_IDLE;
        if (cfg_continuous && !stop_req) begin
          scan_mask_next = cfg_mask;
          if (enc_found) begin
            cur_ch_next = enc_ch;
            state_next  = ST_CMD;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Sticky flags: a same-cycle set wins over the clear.
    done_flag_next   = done_set | (done_flag_reg & ~irq_clr);
    err_timeout_next = tmo_set  | (err_timeout_reg & ~err_clr);
    err_channel_next = chan_set | (err_channel_reg & ~err_clr);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg       <= ST_IDLE;
      scan_mask_reg   <= '0;
      cur_ch_reg      <= '0;
      tmo_cnt_reg     <= '0;
      trig_q_reg      <= 1'b0;
      stop_pend_reg   <= 1'b0;
      done_flag_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_channel_reg <= 1'b0;
      res_we_reg      <= 1'b0;
      res_addr_reg    <= '0;
      res_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      scan_mask_reg   <= scan_mask_next;
      cur_ch_reg      <= cur_ch_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      trig_q_reg      <= ADC_Trigger;
      stop_pend_reg   <= stop_pend_next;
      done_flag_reg   <= done_flag_next;
      err_timeout_reg <= err_timeout_next;
      err_channel_reg <= err_channel_next;
      res_we_reg      <= res_we_next;
      res_addr_reg    <= res_addr_next;
      res_data_reg    <= res_data_next;
    end
  end

  assign ADC_C_Valid   = (state_reg == ST_CMD);
  assign ADC_C_Channel = ADC_C_Valid ? cur_ch_reg : '0;
  assign ADC_C_SOP     = ADC_C_Valid;
  assign ADC_C_EOP     = ADC_C_Valid;
  assign res_we        = res_we_reg;
  assign res_addr      = res_addr_reg;
  assign res_data      = res_data_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done_flag     = done_flag_reg;
  assign err_timeout   = err_timeout_reg;
  assign err_channel   = err_channel_reg;
  assign ADC_Interrupt = done_flag_reg & cfg_irq_en;

endmodule

// File: tb/tb_mfp_adc_max10_scan_sequencer.sv
// Directed bench for the scan sequencer: an ADC IP stand-in answers commands,
// a scoreboard predicts command order and result writes from the mask rules.
module tb_mfp_adc_max10_scan_sequencer;

  localparam int CH_COUNT = 17;
  localparam int TIMEOUT  = 1023;

  logic                CLK = 1'b0;
  logic                RESETn = 1'b0;
  logic [CH_COUNT-1:0] cfg_mask = '0;
  logic                cfg_continuous = 1'b0;
  logic                cfg_trig_en = 1'b0;
  logic                cfg_irq_en = 1'b0;
  logic                sw_start = 1'b0;
  logic                sw_stop = 1'b0;
  logic                irq_clr = 1'b0;
  logic                err_clr = 1'b0;
  logic                ADC_Trigger = 1'b0;
  logic                ADC_C_Valid;
  logic [4:0]          ADC_C_Channel;
  logic                ADC_C_SOP;
  logic                ADC_C_EOP;
  logic                ADC_C_Ready = 1'b1;
  logic                ADC_R_Valid = 1'b0;
  logic [4:0]          ADC_R_Channel = '0;
  logic [11:0]         ADC_R_Data = '0;
  logic                res_we;
  logic [4:0]          res_addr;
  logic [11:0]         res_data;
  logic                busy;
  logic                done_flag;
  logic                err_timeout;
  logic                err_channel;
  logic                ADC_Interrupt;

  mfp_adc_max10_scan_sequencer #(
    .CH_COUNT (CH_COUNT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .cfg_mask       (cfg_mask),
    .cfg_continuous (cfg_continuous),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_irq_en     (cfg_irq_en),
    .sw_start       (sw_start),
    .sw_stop        (sw_stop),
    .irq_clr        (irq_clr),
    .err_clr        (err_clr),
    .ADC_Trigger    (ADC_Trigger),
    .ADC_C_Valid    (ADC_C_Valid),
    .ADC_C_Channel  (ADC_C_Channel),
    .ADC_C_SOP      (ADC_C_SOP),
    .ADC_C_EOP      (ADC_C_EOP),
    .ADC_C_Ready    (ADC_C_Ready),
    .ADC_R_Valid    (ADC_R_Valid),
    .ADC_R_Channel  (ADC_R_Channel),
    .ADC_R_Data     (ADC_R_Data),
    .res_we         (res_we),
    .res_addr       (res_addr),
    .res_data       (res_data),
    .busy           (busy),
    .done_flag      (done_flag),
    .err_timeout    (err_timeout),
    .err_channel    (err_channel),
    .ADC_Interrupt  (ADC_Interrupt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic [11:0] data;
    int          at;
  } wr_t;

  int          cmd_exp[$];
  wr_t         wr_exp[$];
  int          wr_log_addr[$];
  int          wr_log_data[$];
  logic [11:0] rsp_tab[32];

  int         hs_count = 0;
  int         hs_cyc = 0;
  bit         rsp_pending = 0;
  int         rsp_cnt = 0;
  logic [4:0] rsp_ch = '0;
  int         rsp_dly = 3;
  bit         rsp_enable = 1;
  bit         corrupt_en = 0;
  logic [4:0] corrupt_from = 5'd2;
  logic [4:0] corrupt_to = 5'd7;
  int         ready_stall = 0;
  bit         prev_stall = 0;
  logic [4:0] prev_ch = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Per-cycle compare: command ordering, Avalon-ST hold rule, result writes.
  always @(negedge CLK) begin
    if (!RESETn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("cmd_hold_valid", ADC_C_Valid, 1);
        check("cmd_hold_channel", ADC_C_Channel, prev_ch);
      end
      if (ADC_C_Valid && ADC_C_Ready) begin
        hs_count++;
        hs_cyc = cyc;
        check("cmd_sop", ADC_C_SOP, 1);
        check("cmd_eop", ADC_C_EOP, 1);
        if (cmd_exp.size() == 0) fail_now("unexpected_command");
        else check("cmd_channel", ADC_C_Channel, cmd_exp.pop_front());
        if (rsp_enable) begin
          rsp_pending = 1;
          rsp_cnt     = rsp_dly;
          rsp_ch      = ADC_C_Channel;
        end
      end
      prev_stall = ADC_C_Valid && !ADC_C_Ready;
      prev_ch    = ADC_C_Channel;
      if (res_we) begin
        wr_t e;
        wr_log_addr.push_back(int'(res_addr));
        wr_log_data.push_back(int'(res_data));
        if (wr_exp.size() == 0) fail_now("unexpected_res_we");
        else begin
          e = wr_exp.pop_front();
          check("res_addr", res_addr, e.addr);
          check("res_data", res_data, e.data);
          check("res_we_latency", cyc, e.at + 1);
        end
      end
    end
  end

  // ADC IP stand-in: Ready stalls and delayed single-beat responses.
  always begin
    @(posedge CLK);
    #1;
    ADC_R_Valid = 1'b0;
    if (rsp_pending) begin
      if (rsp_cnt == 0) begin
        rsp_pending = 0;
        ADC_R_Valid = 1'b1;
        ADC_R_Data  = rsp_tab[rsp_ch];
        if (corrupt_en && rsp_ch == corrupt_from) begin
          ADC_R_Channel = corrupt_to;
        end else begin
          ADC_R_Channel = rsp_ch;
          wr_exp.push_back('{rsp_ch, rsp_tab[rsp_ch], cyc});
        end
      end else begin
        rsp_cnt--;
      end
    end
    ADC_C_Ready = !(ready_stall > 0 && ADC_C_Valid);
    if (!ADC_C_Ready) ready_stall--;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    sw_start = 1'b1;
    tick(1);
    sw_start = 1'b0;
  endtask

  task automatic push_scan(input logic [CH_COUNT-1:0] m);
    for (int i = 0; i < CH_COUNT; i++) if (m[i]) cmd_exp.push_back(i);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick(1);
    if (busy) fail_now("wait_idle_budget_expired");
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget && hs_count < target; i++) tick(1);
    if (hs_count < target) fail_now("wait_handshake_budget_expired");
  endtask

  task automatic clear_flags();
    irq_clr = 1'b1;
    err_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic queues_empty(input string name);
    check({name, "_cmd_queue"}, cmd_exp.size(), 0);
    check({name, "_wr_queue"}, wr_exp.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    for (int i = 0; i < 32; i++) rsp_tab[i] = 12'((i * 37 + 5) & 12'hFFF);
    rsp_tab[0] = 12'h123;
    rsp_tab[2] = 12'hABC;

    // Reset state
    tick(3);
    check("rst_valid", ADC_C_Valid, 0);
    check("rst_channel", ADC_C_Channel, 0);
    check("rst_res_we", res_we, 0);
    check("rst_res_addr", res_addr, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_flag, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_channel", err_channel, 0);
    check("rst_irq", ADC_Interrupt, 0);
    RESETn = 1'b1;
    tick(2);

    // 1: two-channel scan, interrupt gating
    cfg_mask = 17'h00005;
    push_scan(cfg_mask);
    wr_log_addr.delete();
    wr_log_data.delete();
    pulse_start();
    check("t1_valid_after_start", ADC_C_Valid, 1);
    check("t1_first_channel", ADC_C_Channel, 0);
    wait_idle(200);
    check("t1_done", done_flag, 1);
    check("t1_irq_disabled", ADC_Interrupt, 0);
    check("t1_err_channel", err_channel, 0);
    check("t1_write_count", wr_log_addr.size(), 2);
    if (wr_log_addr.size() == 2) begin
      check("t1_wr0_addr", wr_log_addr[0], 0);
      check("t1_wr0_data", wr_log_data[0], 32'h123);
      check("t1_wr1_addr", wr_log_addr[1], 2);
      check("t1_wr1_data", wr_log_data[1], 32'hABC);
    end
    cfg_irq_en = 1'b1;
    #1;
    check("t1_irq_enabled", ADC_Interrupt, 1);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    check("t1_done_cleared", done_flag, 0);
    check("t1_irq_cleared", ADC_Interrupt, 0);
    queues_empty("t1");

    // 2: Ready held low for 5 cycles on the first command
    cfg_mask = 17'h00011;
    push_scan(cfg_mask);
    hs0 = hs_count;
    ready_stall = 5;
    pulse_start();
    wait_idle(200);
    check("t2_commands", hs_count - hs0, 2);
    check("t2_done", done_flag, 1);
    queues_empty("t2");
    clear_flags();

    // 3: response never arrives
    rsp_enable = 0;
    cfg_mask = 17'h00008;
    push_scan(cfg_mask);
    hs0 = hs_count;
    wr_log_addr.delete();
    pulse_start();
    wait_hs(hs0 + 1, 20);
    for (int i = 0; i < TIMEOUT + 50 && cyc < hs_cyc + TIMEOUT; i++) tick(1);
    check("t3_busy_last_wait_cycle", busy, 1);
    check("t3_no_timeout_yet", err_timeout, 0);
    tick(1);
    check("t3_busy", busy, 0);
    check("t3_err_timeout", err_timeout, 1);
    check("t3_done", done_flag, 0);
    check("t3_no_writes", wr_log_addr.size(), 0);
    rsp_enable = 1;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_err_cleared", err_timeout, 0);
    queues_empty("t3");

    // 4: wrong response channel on ch2
    corrupt_en = 1;
    cfg_mask = 17'h00016;
    push_scan(cfg_mask);
    wr_log_addr.delete();
    pulse_start();
    wait_idle(200);
    check("t4_err_channel", err_channel, 1);
    check("t4_done", done_flag, 1);
    check("t4_err_timeout", err_timeout, 0);
    check("t4_write_count", wr_log_addr.size(), 2);
    if (wr_log_addr.size() == 2) begin
      check("t4_wr0_addr", wr_log_addr[0], 1);
      check("t4_wr1_addr", wr_log_addr[1], 4);
    end
    corrupt_en = 0;
    queues_empty("t4");
    clear_flags();

    // 5: continuous scans, stop during the third scan
    cfg_mask = 17'h00003;
    cfg_continuous = 1'b1;
    for (int s = 0; s < 3; s++) push_scan(cfg_mask);
    hs0 = hs_count;
    pulse_start();
    wait_hs(hs0 + 5, 400);
    sw_stop = 1'b1;
    tick(1);
    sw_stop = 1'b0;
    wait_idle(300);
    check("t5_commands", hs_count - hs0, 6);
    check("t5_done", done_flag, 1);
    tick(20);
    check("t5_stays_idle", busy, 0);
    check("t5_no_restart", hs_count - hs0, 6);
    cfg_continuous = 1'b0;
    queues_empty("t5");
    clear_flags();

    // 6: trigger edge with sw_start, start while busy, empty mask, trigger only
    cfg_mask = 17'h00002;
    cfg_trig_en = 1'b1;
    push_scan(cfg_mask);
    hs0 = hs_count;
    ADC_Trigger = 1'b1;
    pulse_start();
    tick(1);
    pulse_start();
    wait_idle(200);
    ADC_Trigger = 1'b0;
    tick(20);
    check("t6_single_scan", hs_count - hs0, 1);
    cfg_mask = '0;
    pulse_start();
    check("t6_empty_mask_idle", busy, 0);
    tick(5);
    check("t6_empty_mask_no_cmd", hs_count - hs0, 1);
    cfg_mask = 17'h00002;
    push_scan(cfg_mask);
    ADC_Trigger = 1'b1;
    tick(1);
    ADC_Trigger = 1'b0;
    check("t6_trigger_start", busy, 1);
    wait_idle(200);
    check("t6_trigger_scan", hs_count - hs0, 2);
    queues_empty("t6");

    // 7: reset during WAIT_RSP
    rsp_dly = 10;
    cfg_irq_en = 1'b1;
    check("t7_irq_before_reset", ADC_Interrupt, 1);
    cfg_mask = 17'h00001;
    push_scan(cfg_mask);
    hs0 = hs_count;
    pulse_start();
    wait_hs(hs0 + 1, 20);
    tick(2);
    check("t7_busy_before_reset", busy, 1);
    RESETn = 1'b0;
    #1;
    check("t7_valid", ADC_C_Valid, 0);
    check("t7_channel", ADC_C_Channel, 0);
    check("t7_res_we", res_we, 0);
    check("t7_res_addr", res_addr, 0);
    check("t7_res_data", res_data, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done_flag, 0);
    check("t7_err_timeout", err_timeout, 0);
    check("t7_err_channel", err_channel, 0);
    check("t7_irq", ADC_Interrupt, 0);
    rsp_pending = 0;
    cmd_exp.delete();
    wr_exp.delete();
    tick(2);
    RESETn = 1'b1;
    rsp_dly = 3;
    tick(15);
    check("t7_idle_after_reset", busy, 0);
    queues_empty("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
